// File: rtl/qtree_operand_sequencer.sv
// qtree_operand_sequencer
//   Merges NUM_CH AXI-Stream operand channels onto the single token stream
//   consumed by a quadtree accelerator wrapper. Each channel is buffered in
//   its own FIFO. Operands are emitted whole, in strict channel order
//   0..NUM_CH-1, repeating. The output carries the source channel on m_tuser,
//   a per-operand token count, and a pulse when the last operand of a round
//   has been accepted downstream.
//
// Ports
//   aclk        clock, everything on the rising edge
//   areset      synchronous active-high reset
//   s_tdata     NUM_CH packed tokens; channel c at [c*TOKEN_W +: TOKEN_W]
//   s_tvalid    per-channel valid
//   s_tlast     per-channel last token of an operand
//   s_tready    per-channel ready (FIFO not full; low during reset)
//   m_tdata     merged token
//   m_tvalid    merged valid
//   m_tlast     last token of the current operand
//   m_tuser     channel index of m_tdata
//   m_tready    downstream ready
//   tok_count   tokens emitted for the current operand, including m_tdata
//   round_done  one-cycle pulse after the last token of channel NUM_CH-1
//               is accepted downstream
//   cnt_ovf     sticky: some operand exceeded 2^CNT_W-1 tokens
module qtree_operand_sequencer #(
   parameter int unsigned TOKEN_W    = 67,
   parameter int unsigned NUM_CH     = 3,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned CNT_W      = 16,
   localparam int unsigned USER_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                      aclk,
   input  logic                      areset,
   input  logic [NUM_CH*TOKEN_W-1:0] s_tdata,
   input  logic [NUM_CH-1:0]         s_tvalid,
   input  logic [NUM_CH-1:0]         s_tlast,
   output logic [NUM_CH-1:0]         s_tready,
   output logic [TOKEN_W-1:0]        m_tdata,
   output logic                      m_tvalid,
   output logic                      m_tlast,
   output logic [USER_W-1:0]         m_tuser,
   input  logic                      m_tready,
   output logic [CNT_W-1:0]          tok_count,
   output logic                      round_done,
   output logic                      cnt_ovf
);

   localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned FCNT_W = PTR_W + 1;

   localparam logic [USER_W-1:0] LastCh = USER_W'(NUM_CH - 1);
   localparam logic [CNT_W-1:0]  CntMax = {CNT_W{1'b1}};
   localparam logic [FCNT_W-1:0] Full   = FCNT_W'(FIFO_DEPTH);

   // FIFO entries are {tlast, tdata}
   logic [TOKEN_W:0]    fifo_head [NUM_CH];
   logic [NUM_CH-1:0]   fifo_empty;
   logic [NUM_CH-1:0]   fifo_wr;
   logic [NUM_CH-1:0]   fifo_rd;

   logic [USER_W-1:0]   cur_ch_q;
   logic                first_tok_q;
   logic [TOKEN_W:0]    head_sel;
   logic                head_valid;
   logic                load;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [TOKEN_W:0]    mem [FIFO_DEPTH];
      logic [PTR_W-1:0]    wr_ptr_q;
      logic [PTR_W-1:0]    rd_ptr_q;
      logic [FCNT_W-1:0]   fcnt_q;

      // Ready looks only at the registered count, so a full FIFO never
      // accepts a write even if it is being read in the same cycle.
      assign s_tready[c]   = !areset && (fcnt_q != Full);
      assign fifo_empty[c] = (fcnt_q == '0);
      assign fifo_wr[c]    = s_tvalid[c] && s_tready[c];
      assign fifo_rd[c]    = load && (cur_ch_q == USER_W'(c));
      assign fifo_head[c]  = mem[rd_ptr_q];

      always_ff @(posedge aclk) begin
         if (fifo_wr[c]) begin
            mem[wr_ptr_q] <= {s_tlast[c], s_tdata[c*TOKEN_W +: TOKEN_W]};
         end
      end

      always_ff @(posedge aclk) begin
         if (areset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcnt_q   <= '0;
         end else begin
            if (fifo_wr[c]) begin
               wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (fifo_rd[c]) begin
               rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (fifo_wr[c] && !fifo_rd[c]) begin
               fcnt_q <= fcnt_q + 1'b1;
            end else if (!fifo_wr[c] && fifo_rd[c]) begin
               fcnt_q <= fcnt_q - 1'b1;
            end
         end
      end
   end

   // Head of the FIFO belonging to the channel currently being serviced
   always_comb begin
      head_sel   = '0;
      head_valid = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (cur_ch_q == USER_W'(c)) begin
            head_sel   = fifo_head[c];
            head_valid = !fifo_empty[c];
         end
      end
   end

   assign load = (!m_tvalid || m_tready) && head_valid;

   always_ff @(posedge aclk) begin
      if (areset) begin
         m_tvalid    <= 1'b0;
         m_tdata     <= '0;
         m_tlast     <= 1'b0;
         m_tuser     <= '0;
         cur_ch_q    <= '0;
         first_tok_q <= 1'b1;
         tok_count   <= '0;
         cnt_ovf     <= 1'b0;
         round_done  <= 1'b0;
      end else begin
         round_done <= m_tvalid && m_tready && m_tlast && (m_tuser == LastCh);

         if (load) begin
            m_tvalid    <= 1'b1;
            m_tdata     <= head_sel[TOKEN_W-1:0];
            m_tlast     <= head_sel[TOKEN_W];
            m_tuser     <= cur_ch_q;
            // The token after a tlast starts a new operand
            first_tok_q <= head_sel[TOKEN_W];

            if (first_tok_q) begin
               tok_count <= CNT_W'(1);
            end else if (tok_count == CntMax) begin
               cnt_ovf <= 1'b1;
            end else begin
               tok_count <= tok_count + 1'b1;
            end

            // Advance straight away so the next load can come from the
            // next channel without a bubble.
            if (head_sel[TOKEN_W]) begin
               cur_ch_q <= (cur_ch_q == LastCh) ? '0 : cur_ch_q + 1'b1;
            end
         end else if (m_tready) begin
            m_tvalid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_qtree_operand_sequencer.sv
// tb_qtree_operand_sequencer
//   Scoreboard bench for qtree_operand_sequencer (NUM_CH=3, FIFO_DEPTH=4,
//   CNT_W=3). Accepted input tokens are pushed to per-channel queues; each
//   output handshake pops from the channel the sequencer should be serving
//   and checks data, tlast, tuser, tok_count and cnt_ovf.
module tb_qtree_operand_sequencer;

   localparam int unsigned TOKEN_W    = 67;
   localparam int unsigned NUM_CH     = 3;
   localparam int unsigned FIFO_DEPTH = 4;
   localparam int unsigned CNT_W      = 3;
   localparam int unsigned USER_W     = 2;

   logic                      aclk = 1'b0;
   logic                      areset = 1'b1;
   logic [NUM_CH*TOKEN_W-1:0] s_tdata;
   logic [NUM_CH-1:0]         s_tvalid;
   logic [NUM_CH-1:0]         s_tlast;
   logic [NUM_CH-1:0]         s_tready;
   logic [TOKEN_W-1:0]        m_tdata;
   logic                      m_tvalid;
   logic                      m_tlast;
   logic [USER_W-1:0]         m_tuser;
   logic                      m_tready = 1'b1;
   logic [CNT_W-1:0]          tok_count;
   logic                      round_done;
   logic                      cnt_ovf;

   qtree_operand_sequencer #(
      .TOKEN_W    (TOKEN_W),
      .NUM_CH     (NUM_CH),
      .FIFO_DEPTH (FIFO_DEPTH),
      .CNT_W      (CNT_W)
   ) u_dut (
      .aclk       (aclk),
      .areset     (areset),
      .s_tdata    (s_tdata),
      .s_tvalid   (s_tvalid),
      .s_tlast    (s_tlast),
      .s_tready   (s_tready),
      .m_tdata    (m_tdata),
      .m_tvalid   (m_tvalid),
      .m_tlast    (m_tlast),
      .m_tuser    (m_tuser),
      .m_tready   (m_tready),
      .tok_count  (tok_count),
      .round_done (round_done),
      .cnt_ovf    (cnt_ovf)
   );

   always #5 aclk = ~aclk;

   // Input drivers
   logic [TOKEN_W-1:0] drv_data [NUM_CH];
   logic [NUM_CH-1:0]  drv_valid = '0;
   logic [NUM_CH-1:0]  drv_last = '0;

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         s_tdata[c*TOKEN_W +: TOKEN_W] = drv_data[c];
      end
   end
   assign s_tvalid = drv_valid;
   assign s_tlast  = drv_last;

   // Scoreboard and reference model state
   logic [TOKEN_W:0]   exp_q [NUM_CH][$];
   int                 exp_ch = 0;
   bit                 first_m = 1'b1;
   logic [CNT_W-1:0]   cnt_m = '0;
   bit                 ovf_m = 1'b0;
   bit                 rd_exp = 1'b0;
   bit                 mon_en = 1'b0;
   int                 hs_cnt = 0;
   int                 cyc = 0;
   int                 hs_cyc [$];
   int                 tok_serial = 0;
   bit                 bp_done = 1'b0;
   int                 bp_k = 0;

   bit                 stall_prev = 1'b0;
   logic [TOKEN_W-1:0] prev_data;
   logic               prev_last;
   logic [USER_W-1:0]  prev_user;
   logic [TOKEN_W:0]   ent;

   int                 n_checks = 0;
   int                 n_pass = 0;

   task automatic check_eq(input string tag, input logic [127:0] got,
                           input logic [127:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge aclk);
      #1;
   endtask

   // Present one token and hold it until the DUT accepts it
   task automatic send_tok(input int ch, input logic [TOKEN_W-1:0] d, input logic last);
      int   waited = 0;
      logic acc = 1'b0;
      drv_data[ch]  = d;
      drv_last[ch]  = last;
      drv_valid[ch] = 1'b1;
      while (!acc && waited < 300) begin
         @(negedge aclk);
         acc = s_tready[ch];
         @(posedge aclk);
         #1;
         waited++;
      end
      if (acc) begin
         exp_q[ch].push_back({last, d});
      end else begin
         check_eq("tready_timeout", waited, 0);
      end
   endtask

   task automatic send_operand(input int ch, input int n);
      for (int i = 0; i < n; i++) begin
         tok_serial++;
         send_tok(ch, {3'(ch), 32'(tok_serial), 32'($urandom)}, i == n - 1);
      end
      drv_valid[ch] = 1'b0;
      drv_last[ch]  = 1'b0;
   endtask

   task automatic wait_drain();
      int   waited = 0;
      logic busy = 1'b1;
      while (busy && waited < 400) begin
         step(1);
         waited++;
         busy = m_tvalid;
         for (int c = 0; c < NUM_CH; c++) begin
            if (exp_q[c].size() != 0) busy = 1'b1;
         end
      end
      check_eq("drain_done", busy, 0);
   endtask

   task automatic flush_model();
      for (int c = 0; c < NUM_CH; c++) exp_q[c].delete();
      exp_ch  = 0;
      first_m = 1'b1;
      cnt_m   = '0;
      ovf_m   = 1'b0;
      rd_exp  = 1'b0;
   endtask

   // Output monitor
   initial begin
      forever begin
         @(negedge aclk);
         cyc++;
         if (mon_en) begin
            check_eq("round_done", round_done, rd_exp);
            rd_exp = 1'b0;
            if (stall_prev) begin
               check_eq("stall_valid", m_tvalid, 1);
               check_eq("stall_data", m_tdata, prev_data);
               check_eq("stall_last", m_tlast, prev_last);
               check_eq("stall_user", m_tuser, prev_user);
            end
            if (m_tvalid && m_tready) begin
               hs_cnt++;
               hs_cyc.push_back(cyc);
               check_eq("out_pending", exp_q[exp_ch].size() != 0, 1);
               if (exp_q[exp_ch].size() != 0) begin
                  ent = exp_q[exp_ch].pop_front();
                  if (first_m) cnt_m = CNT_W'(1);
                  else if (cnt_m == {CNT_W{1'b1}}) ovf_m = 1'b1;
                  else cnt_m = cnt_m + 1'b1;
                  first_m = ent[TOKEN_W];
                  check_eq("data", m_tdata, ent[TOKEN_W-1:0]);
                  check_eq("last", m_tlast, ent[TOKEN_W]);
                  check_eq("user", m_tuser, exp_ch);
                  check_eq("tok_count", tok_count, cnt_m);
                  check_eq("cnt_ovf", cnt_ovf, ovf_m);
                  if (ent[TOKEN_W]) begin
                     if (exp_ch == NUM_CH - 1) rd_exp = 1'b1;
                     exp_ch = (exp_ch + 1) % NUM_CH;
                  end
               end
            end
            stall_prev = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_last  = m_tlast;
            prev_user  = m_tuser;
         end else begin
            stall_prev = 1'b0;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int hs_base;
      int waited;
      for (int c = 0; c < NUM_CH; c++) drv_data[c] = '0;

      // Reset and reset values
      step(3);
      check_eq("rst_tready_held", s_tready, 3'b000);
      areset = 1'b0;
      #1;
      check_eq("rst_tvalid", m_tvalid, 0);
      check_eq("rst_tdata", m_tdata, 0);
      check_eq("rst_tlast", m_tlast, 0);
      check_eq("rst_tuser", m_tuser, 0);
      check_eq("rst_tok_count", tok_count, 0);
      check_eq("rst_round_done", round_done, 0);
      check_eq("rst_cnt_ovf", cnt_ovf, 0);
      check_eq("rst_tready", s_tready, 3'b111);
      mon_en = 1'b1;

      // One single-token operand per channel
      send_operand(0, 1);
      send_operand(1, 1);
      send_operand(2, 1);
      wait_drain();

      // Channels 2 and 1 buffered before channel 0 arrives
      hs_cyc.delete();
      send_operand(2, 3);
      send_operand(1, 2);
      send_operand(0, 4);
      wait_drain();
      check_eq("order_count", hs_cyc.size(), 9);
      if (hs_cyc.size() == 9) check_eq("no_gaps", hs_cyc[8] - hs_cyc[0], 8);

      // Channel 1 fills its FIFO while channel 0 is still owed
      fork
         send_operand(1, 6);
         begin
            step(10);
            check_eq("full_tready", s_tready[1], 0);
            check_eq("full_accepted", exp_q[1].size(), FIFO_DEPTH);
            send_operand(0, 1);
         end
      join
      send_operand(2, 1);
      wait_drain();

      // Back-pressure pattern 1,0,0,1 while channel 0 streams 10 tokens
      bp_done = 1'b0;
      bp_k    = 0;
      fork
         begin
            send_operand(0, 10);
            send_operand(1, 1);
            send_operand(2, 1);
            wait_drain();
            bp_done = 1'b1;
         end
         begin
            while (!bp_done) begin
               m_tready = (bp_k % 4 == 0) || (bp_k % 4 == 3);
               bp_k++;
               step(1);
            end
         end
      join
      m_tready = 1'b1;
      step(1);
      check_eq("bp_ovf_set", cnt_ovf, 1);

      // Reset after 2 of 5 channel-0 tokens are emitted
      m_tready = 1'b0;
      send_operand(0, 5);
      hs_base  = hs_cnt;
      m_tready = 1'b1;
      waited   = 0;
      while (hs_cnt < hs_base + 2 && waited < 50) begin
         step(1);
         waited++;
      end
      check_eq("mid_two_emitted", hs_cnt - hs_base, 2);
      m_tready = 1'b0;
      mon_en   = 1'b0;
      areset   = 1'b1;
      #1;
      check_eq("mid_rst_tready", s_tready, 3'b000);
      step(1);
      areset = 1'b0;
      flush_model();
      #1;
      check_eq("mid_tvalid", m_tvalid, 0);
      check_eq("mid_tok_count", tok_count, 0);
      check_eq("mid_cnt_ovf", cnt_ovf, 0);
      check_eq("mid_tready", s_tready, 3'b111);
      m_tready = 1'b1;
      mon_en   = 1'b1;
      step(1);
      send_operand(0, 3);
      send_operand(1, 1);
      send_operand(2, 1);
      wait_drain();

      // Counter saturation with a 9-token operand
      send_operand(0, 9);
      send_operand(1, 2);
      send_operand(2, 1);
      wait_drain();
      step(2);
      check_eq("ovf_sticky", cnt_ovf, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
